imem_loader: RTL and testbench

Boot-time program loader that writes the instruction memory read by the fetch stage. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes them sequentially starting at the first instruction address (32). It holds the core in reset while loading, then releases it with a one-cycle `done` pulse so fetch starts from PC = 32.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package imem_loader_pkg;

    // First instruction word; the words below it hold interrupt entries.
    localparam int IMEM_START_ADDR = 32;
    // Instruction memory address width in words.
    localparam int IMEM_ADDR_W     = 19;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_HI  = 3'd1,
        ST_HDR_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_DONE    = 3'd5
    } loader_state_t;

    // Number of words that fit between the first instruction address and the top of memory.
    function automatic logic [31:0] imem_capacity(input int addr_w, input int start_addr);
        return (32'd1 << addr_w) - 32'(start_addr);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream input, session control and instruction memory write port of the loader.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready are
// both high. The sender keeps in_byte stable while in_valid is high and not yet
// taken; the loader raises in_ready from its state alone, never from in_valid.
interface imem_loader_if #(
    parameter int ADDR_W = imem_loader_pkg::IMEM_ADDR_W
);
    logic              start;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              core_hold;
    logic              done;
    logic              error;

    // Host side: starts sessions, supplies bytes, observes memory writes and status.
    modport master (
        output start, in_byte, in_valid,
        input  in_ready, mem_write, mem_addr, mem_data, core_hold, done, error
    );

    // Loader side.
    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, mem_write, mem_addr, mem_data, core_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: reads a word count header and big-endian 16-bit words from a byte
// stream, writes them to instruction memory from START_ADDR upward and holds the
// core in reset until the session ends.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int START_ADDR = IMEM_START_ADDR
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output loader_state_t dbg_state
);

    localparam logic [31:0]       CAPACITY = imem_capacity(ADDR_W, START_ADDR);
    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    loader_state_t     state;
    loader_state_t     state_next;

    logic [7:0]        cnt_hi_q;
    logic [15:0]       remain_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_data_q;
    logic              error_q;

    logic              in_ready;
    logic              core_hold;
    logic              done;

    logic              take;
    logic [15:0]       header_n;
    logic              overflow;

    assign take     = bus.in_valid && in_ready;
    assign header_n = {cnt_hi_q, bus.in_byte};
    // The whole session is rejected up front, so the address counter never wraps.
    assign overflow = {16'd0, header_n} > CAPACITY;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode; a missing in_valid simply holds the current state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (bus.start) state_next = ST_HDR_HI;
            ST_HDR_HI:  if (take) state_next = ST_HDR_LO;
            ST_HDR_LO: begin
                if (take) begin
                    if (overflow || header_n == 16'd0) state_next = ST_DONE;
                    else                              state_next = ST_DATA_HI;
                end
            end
            ST_DATA_HI: if (take) state_next = ST_DATA_LO;
            ST_DATA_LO: begin
                if (take) state_next = (remain_q == 16'd1) ? ST_DONE : ST_DATA_HI;
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Status outputs are pure functions of the registered state.
    always_comb begin
        in_ready  = 1'b0;
        core_hold = 1'b0;
        done      = 1'b0;
        case (state)
            ST_HDR_HI, ST_HDR_LO, ST_DATA_HI, ST_DATA_LO: begin
                in_ready  = 1'b1;
                core_hold = 1'b1;
            end
            ST_DONE: begin
                core_hold = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // Header capture, byte pairing, address counting and the registered write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_hi_q    <= 8'd0;
            remain_q    <= 16'd0;
            hi_q        <= 8'd0;
            addr_q      <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= 16'd0;
            error_q     <= 1'b0;
        end else begin
            mem_write_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        error_q <= 1'b0;
                        addr_q  <= START_A;
                    end
                end
                ST_HDR_HI: if (take) cnt_hi_q <= bus.in_byte;
                ST_HDR_LO: begin
                    if (take) begin
                        remain_q <= header_n;
                        if (overflow) error_q <= 1'b1;
                    end
                end
                ST_DATA_HI: if (take) hi_q <= bus.in_byte;
                ST_DATA_LO: begin
                    if (take) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_data_q  <= {hi_q, bus.in_byte};
                        addr_q      <= addr_q + ADDR_ONE;
                        remain_q    <= remain_q - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.core_hold = core_hold;
    assign bus.done      = done;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.error     = error_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader built with a 64-word memory so the capacity limit (32 words) is reachable.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 6;
    localparam int START  = IMEM_START_ADDR;
    localparam int CAP    = (1 << ADDR_W) - START;
    localparam int W      = ADDR_W + 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    loader_state_t dbg_state;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W), .START_ADDR(START)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is idle, loading (consuming bytes) or finishing (one cycle).
    // Bytes are counted from the header; word k goes to START+k.
    int           m_phase = 0;
    int           m_idx   = 0;
    int           m_n     = 0;
    logic         m_err   = 1'b0;
    logic         m_write = 1'b0;
    logic [7:0]   m_hi    = 8'd0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk or negedge reset) begin : model
        int j;
        int ai;
        logic [ADDR_W-1:0] a;
        if (!reset) begin
            m_phase = 0;
            m_err   = 1'b0;
            m_write = 1'b0;
            exp_q.delete();
        end else begin
            m_write = 1'b0;
            if (m_phase == 0) begin
                if (bus.start) begin
                    m_phase = 1;
                    m_idx   = 0;
                    m_err   = 1'b0;
                end
            end else if (m_phase == 1) begin
                if (bus.in_valid) begin
                    if (m_idx == 0) begin
                        m_n = int'(bus.in_byte) * 256;
                    end else if (m_idx == 1) begin
                        m_n = m_n + int'(bus.in_byte);
                        if (m_n > CAP) begin
                            m_err   = 1'b1;
                            m_phase = 2;
                        end else if (m_n == 0) begin
                            m_phase = 2;
                        end
                    end else begin
                        j = m_idx - 2;
                        if (j % 2 == 0) begin
                            m_hi = bus.in_byte;
                        end else begin
                            ai = START + j / 2;
                            a  = ai[ADDR_W-1:0];
                            m_write = 1'b1;
                            exp_q.push_back({a, m_hi, bus.in_byte});
                            if (j / 2 + 1 == m_n) m_phase = 2;
                        end
                    end
                    m_idx++;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Per-cycle compare plus a log of observed writes for the directed checks.
    logic              chk_en   = 1'b0;
    int                cyc      = 0;
    int                hold_cnt = 0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [15:0]       wd_q[$];
    int                wc_q[$];
    logic              wdone_q[$];

    always @(negedge clk) begin : compare
        logic [W-1:0] e;
        cyc++;
        if (chk_en && reset) begin
            check("in_ready",  32'(bus.in_ready),  32'(m_phase == 1));
            check("core_hold", 32'(bus.core_hold), 32'(m_phase != 0));
            check("done",      32'(bus.done),      32'(m_phase == 2));
            check("error",     32'(bus.error),     32'(m_err));
            check("mem_write", 32'(bus.mem_write), 32'(m_write));
            if (m_write && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_addr_data", 32'({bus.mem_addr, bus.mem_data}), 32'(e));
            end
            if (bus.mem_write) begin
                wa_q.push_back(bus.mem_addr);
                wd_q.push_back(bus.mem_data);
                wc_q.push_back(cyc);
                wdone_q.push_back(bus.done);
            end
            if (bus.core_hold) hold_cnt++;
        end
    end

    // Driver tasks; each is entered and left just after a falling edge.
    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        wdone_q.delete();
        hold_cnt = 0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (!bus.in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("ready_timeout", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (bus.core_hold && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("idle_timeout", 32'(bus.core_hold), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        int noise;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'd0;

        // Reset values.
        #2;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_mem_data",  32'(bus.mem_data),  32'd0);
        check("rst_core_hold", 32'(bus.core_hold), 32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_error",     32'(bus.error),     32'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Reset mid-session after the header and one high byte.
        clear_logs();
        do_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h40);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst_core_hold", 32'(bus.core_hold), 32'd0);
        check("midrst_done",      32'(bus.done),      32'd0);
        check("midrst_mem_write", 32'(bus.mem_write), 32'd0);
        check("midrst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("midrst_mem_data",  32'(bus.mem_data),  32'd0);
        check("midrst_error",     32'(bus.error),     32'd0);
        check("midrst_state",     32'(dbg_state),     32'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_no_write", 32'(wa_q.size()), 32'd0);

        // Basic load: 00 02 40 00 12 34 back to back.
        @(negedge clk);
        clear_logs();
        do_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34);
        wait_idle();
        @(negedge clk);
        #1;
        check("basic_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("basic_addr0", 32'(wa_q[0]), 32'd32);
            check("basic_data0", 32'(wd_q[0]), 32'h4000);
            check("basic_addr1", 32'(wa_q[1]), 32'd33);
            check("basic_data1", 32'(wd_q[1]), 32'h1234);
            check("basic_done0", 32'(wdone_q[0]), 32'd0);
            check("basic_done1", 32'(wdone_q[1]), 32'd1);
            check("basic_wgap",  32'(wc_q[1] - wc_q[0]), 32'd2);
        end
        // Session length counts the start cycle plus every cycle core_hold is high.
        check("basic_session_len", 32'(hold_cnt + 1), 32'd8);

        // Same stream with a 3-cycle in_valid gap inside word 2.
        clear_logs();
        do_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h12);
        repeat (3) @(negedge clk);
        send_byte(8'h34);
        wait_idle();
        @(negedge clk);
        #1;
        check("gap_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check("gap_addr0", 32'(wa_q[0]), 32'd32);
            check("gap_data0", 32'(wd_q[0]), 32'h4000);
            check("gap_addr1", 32'(wa_q[1]), 32'd33);
            check("gap_data1", 32'(wd_q[1]), 32'h1234);
            check("gap_wgap",  32'(wc_q[1] - wc_q[0]), 32'd5);
        end

        // Empty session: done in the cycle right after the count low byte is taken.
        clear_logs();
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
        check("n0_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("n0_done_gone", 32'(bus.done), 32'd0);
        check("n0_error", 32'(bus.error), 32'd0);
        #1;
        check("n0_no_write", 32'(wa_q.size()), 32'd0);

        // Overflow: 33 words do not fit above address 32 in a 64-word memory.
        @(negedge clk);
        clear_logs();
        do_start();
        send_byte(8'h00);
        send_byte(8'h21);
        check("ovf_done",  32'(bus.done),  32'd1);
        check("ovf_error", 32'(bus.error), 32'd1);
        repeat (10) @(negedge clk);
        check("ovf_error_sticky", 32'(bus.error), 32'd1);
        #1;
        check("ovf_no_write", 32'(wa_q.size()), 32'd0);
        @(negedge clk);
        do_start();
        check("ovf_error_cleared", 32'(bus.error), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle();

        // Bytes offered in IDLE are refused; start while busy is ignored.
        clear_logs();
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        do_start();
        send_byte(8'h00);
        send_byte(8'h01);
        bus.start = 1'b1;
        send_byte(8'hBE);
        bus.start = 1'b0;
        send_byte(8'hEF);
        wait_idle();
        repeat (3) @(negedge clk);
        check("busy_start_no_restart", 32'(bus.core_hold), 32'd0);
        #1;
        check("busy_nwrites", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            check("busy_addr", 32'(wa_q[0]), 32'd32);
            check("busy_data", 32'(wd_q[0]), 32'hBEEF);
        end

        // Random sessions with gaps, stray starts and idle-time bytes.
        for (int s = 0; s < 24; s++) begin
            @(negedge clk);
            n = $urandom_range(0, CAP + 4);
            if ($urandom_range(0, 9) == 0) n = $urandom_range(256, 65535);
            noise = $urandom_range(0, 1);
            bus.in_valid = ($urandom_range(0, 1) == 1);
            bus.in_byte  = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.in_valid = 1'b0;
            do_start();
            send_byte(8'(n >> 8));
            send_byte(8'(n));
            if (n <= CAP) begin
                for (int i = 0; i < 2 * n; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    if (noise == 1) bus.start = ($urandom_range(0, 3) == 0);
                    send_byte(8'($urandom_range(0, 255)));
                    bus.start = 1'b0;
                end
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
